// File: rtl/synth_pkg.sv
// Shared types and constants for the synth_prog_mem program/data memory.
package synth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 10;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 3;

    // Out-of-range latencies are pulled to the nearest supported value.
    function automatic int clamp_lat(input int lat);
        if (lat < RD_LAT_MIN) begin
            return RD_LAT_MIN;
        end else if (lat > RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end else begin
            return lat;
        end
    endfunction

endpackage

// File: rtl/synth_mem_array.sv
// DEPTH x DATA_W storage with one write port and a registered read port
// followed by RD_LAT-1 extra output stages and a matching valid pipeline.
module synth_mem_array
    import synth_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    localparam int LAT = clamp_lat(RD_LAT);

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] data_q [LAT];
    logic [DATA_W-1:0] data_d [LAT];
    logic [LAT-1:0]    vld_q;
    logic [LAT-1:0]    vld_d;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < (ADDR_W+1)'(DEPTH));
    endfunction

    // Storage write port; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (we_i && in_range(waddr_i)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read pipeline: data stages only advance behind a valid so the output holds.
    always_comb begin
        vld_d[0] = re_i;
        if (re_i) begin
            data_d[0] = in_range(raddr_i) ? mem_q[raddr_i] : {DATA_W{1'b0}};
        end else begin
            data_d[0] = data_q[0];
        end
        for (int i = 1; i < LAT; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = vld_q[i-1] ? data_q[i-1] : data_q[i];
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rdata_o  = data_q[LAT-1];
    assign rvalid_o = vld_q[LAT-1];

endmodule

// File: rtl/synth_prog_mem.sv
// Program/data memory with a core port and a byte-serial image loader.
// Define SYNTH_PROG_MEM_CHECKSUM_EN to require a trailing checksum word per load.
module synth_prog_mem
    import synth_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk_io,
    input  logic              reset_io,
    input  logic [ADDR_W-1:0] core_addr_io,
    input  logic              core_re_io,
    input  logic              core_to_mem_enable_io,
    input  logic [DATA_W-1:0] core_wdata_io,
    output logic [DATA_W-1:0] core_rdata_io,
    output logic              core_rvalid_io,
    output logic              core_hold_io,
    input  logic              load_start_io,
    input  logic [ADDR_W:0]   load_len_io,
    input  logic [7:0]        load_byte_io,
    input  logic              load_valid_io,
    output logic              load_ready_io,
    output logic              load_done_io,
    output logic              load_err_io
);

    localparam int BYTES = DATA_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE   = (ADDR_W+1)'(1'b1);
    localparam logic [BC_W-1:0] BC_ONE    = BC_W'(1'b1);
    localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   ptr_q, ptr_d, len_q, len_d;
    logic [BC_W-1:0]   bcnt_q, bcnt_d;
    logic [DATA_W-1:0] shift_q, shift_d, sum_q, sum_d;
    logic              done_q, done_d, err_q, err_d;
    logic              hold_q, hold_d, ready_q, ready_d;

    logic              byte_xfer_s, last_byte_s, mem_we_s, core_re_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s, asm_s;
    logic [DATA_W+7:0] cat_s;

    assign byte_xfer_s = load_valid_io & ready_q;
    assign last_byte_s = (bcnt_q == LAST_BYTE);
    assign cat_s       = {shift_q, load_byte_io};
    assign asm_s       = cat_s[DATA_W-1:0];

    // Next-state, loader datapath and memory port steering.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        len_d       = len_q;
        bcnt_d      = bcnt_q;
        shift_d     = shift_q;
        sum_d       = sum_q;
        err_d       = err_q;
        done_d      = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = core_addr_io;
        mem_wdata_s = core_wdata_io;
        core_re_s   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                mem_we_s  = core_to_mem_enable_io;
                core_re_s = core_re_io & ~core_to_mem_enable_io;
                if (core_re_io || core_to_mem_enable_io) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = state_q;
                end
                if (load_start_io) begin
                    err_d  = 1'b0;
                    ptr_d  = {(ADDR_W+1){1'b0}};
                    bcnt_d = {BC_W{1'b0}};
                    sum_d  = {DATA_W{1'b0}};
                    len_d  = load_len_io;
                    if (load_len_io > DEPTH_L) begin
                        err_d = 1'b1;
                    end else if (load_len_io == {(ADDR_W+1){1'b0}}) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    len_d = len_q;
                end
            end
            ST_LOAD: begin
                if (byte_xfer_s && last_byte_s) begin
                    bcnt_d      = {BC_W{1'b0}};
                    shift_d     = asm_s;
                    mem_we_s    = 1'b1;
                    mem_waddr_s = ptr_q[ADDR_W-1:0];
                    mem_wdata_s = asm_s;
                    sum_d       = sum_q + asm_s;
                    ptr_d       = ptr_q + PTR_ONE;
                    if ((ptr_q + PTR_ONE) == len_q) begin
`ifdef SYNTH_PROG_MEM_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        done_d  = 1'b1;
                        state_d = ST_RUN;
`endif
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (byte_xfer_s) begin
                    bcnt_d  = bcnt_q + BC_ONE;
                    shift_d = asm_s;
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
`ifdef SYNTH_PROG_MEM_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_xfer_s && last_byte_s) begin
                    bcnt_d  = {BC_W{1'b0}};
                    err_d   = (asm_s != sum_q);
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end else if (byte_xfer_s) begin
                    bcnt_d  = bcnt_q + BC_ONE;
                    shift_d = asm_s;
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        hold_d  = (state_d == ST_LOAD) || (state_d == ST_CHECK);
        ready_d = hold_d;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_io or negedge reset_io) begin
        if (!reset_io) begin
            state_q <= ST_IDLE;
            ptr_q   <= {(ADDR_W+1){1'b0}};
            len_q   <= {(ADDR_W+1){1'b0}};
            bcnt_q  <= {BC_W{1'b0}};
            shift_q <= {DATA_W{1'b0}};
            sum_q   <= {DATA_W{1'b0}};
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
            ready_q <= ready_d;
        end
    end

    synth_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_array (
        .clk_i    (clk_io),
        .rst_ni   (reset_io),
        .we_i     (mem_we_s),
        .waddr_i  (mem_waddr_s),
        .wdata_i  (mem_wdata_s),
        .re_i     (core_re_s),
        .raddr_i  (core_addr_io),
        .rdata_o  (core_rdata_io),
        .rvalid_o (core_rvalid_io)
    );

    assign core_hold_io  = hold_q;
    assign load_ready_io = ready_q;
    assign load_done_io  = done_q;
    assign load_err_io   = err_q;

endmodule

// File: tb/tb_synth_prog_mem.sv
// Directed self-checking bench for synth_prog_mem (DATA_W=16, DEPTH=1024, RD_LAT=2).
module tb_synth_prog_mem;

    logic        clk_io = 1'b0;
    logic        reset_io;
    logic [9:0]  core_addr_io;
    logic        core_re_io;
    logic        core_to_mem_enable_io;
    logic [15:0] core_wdata_io;
    logic [15:0] core_rdata_io;
    logic        core_rvalid_io;
    logic        core_hold_io;
    logic        load_start_io;
    logic [10:0] load_len_io;
    logic [7:0]  load_byte_io;
    logic        load_valid_io;
    logic        load_ready_io;
    logic        load_done_io;
    logic        load_err_io;

    int n_cmp = 0;
    int n_err = 0;

    synth_prog_mem #(
        .DATA_W (16),
        .ADDR_W (10),
        .DEPTH  (1024),
        .RD_LAT (2)
    ) dut (
        .clk_io                (clk_io),
        .reset_io              (reset_io),
        .core_addr_io          (core_addr_io),
        .core_re_io            (core_re_io),
        .core_to_mem_enable_io (core_to_mem_enable_io),
        .core_wdata_io         (core_wdata_io),
        .core_rdata_io         (core_rdata_io),
        .core_rvalid_io        (core_rvalid_io),
        .core_hold_io          (core_hold_io),
        .load_start_io         (load_start_io),
        .load_len_io           (load_len_io),
        .load_byte_io          (load_byte_io),
        .load_valid_io         (load_valid_io),
        .load_ready_io         (load_ready_io),
        .load_done_io          (load_done_io),
        .load_err_io           (load_err_io)
    );

    always #5 clk_io = ~clk_io;

    task automatic tick();
        @(posedge clk_io);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [10:0] len);
        load_start_io = 1'b1;
        load_len_io   = len;
        tick();
        load_start_io = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        load_valid_io = 1'b1;
        load_byte_io  = b;
        tick();
        load_valid_io = 1'b0;
    endtask

    // Issue one read; with RD_LAT=2 the data shows after the second edge.
    task automatic rd(input string tag, input logic [9:0] a, input logic [15:0] exp);
        core_re_io   = 1'b1;
        core_addr_io = a;
        tick();
        core_re_io = 1'b0;
        chk({tag, "_early"}, {31'd0, core_rvalid_io}, 32'd0);
        tick();
        chk({tag, "_vld"}, {31'd0, core_rvalid_io}, 32'd1);
        chk({tag, "_data"}, {16'd0, core_rdata_io}, {16'd0, exp});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hold"},  {31'd0, core_hold_io},   32'd0);
        chk({tag, "_ready"}, {31'd0, load_ready_io},  32'd0);
        chk({tag, "_done"},  {31'd0, load_done_io},   32'd0);
        chk({tag, "_err"},   {31'd0, load_err_io},    32'd0);
        chk({tag, "_rvld"},  {31'd0, core_rvalid_io}, 32'd0);
        chk({tag, "_rdata"}, {16'd0, core_rdata_io},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] img [8];
        int nbytes;

        reset_io = 1'b0;
        core_addr_io = 10'd0; core_re_io = 1'b0; core_to_mem_enable_io = 1'b0;
        core_wdata_io = 16'd0; load_start_io = 1'b0; load_len_io = 11'd0;
        load_byte_io = 8'd0; load_valid_io = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_io = 1'b1;
        tick();

        // Three-word image; checksum build appends 0x4F20+0x48FF+0x5800 = 0xF01F.
        img[0] = 8'h4F; img[1] = 8'h20; img[2] = 8'h48; img[3] = 8'hFF;
        img[4] = 8'h58; img[5] = 8'h00; img[6] = 8'hF0; img[7] = 8'h1F;
`ifdef SYNTH_PROG_MEM_CHECKSUM_EN
        nbytes = 8;
`else
        nbytes = 6;
`endif
        start_load(11'd3);
        chk("load_hold", {31'd0, core_hold_io}, 32'd1);
        chk("load_ready", {31'd0, load_ready_io}, 32'd1);
        core_re_io = 1'b1;
        core_addr_io = 10'd0;
        for (int i = 0; i < nbytes - 1; i++) begin
            send(img[i]);
            chk("load_mid_done", {31'd0, load_done_io}, 32'd0);
            chk("load_mid_rvld", {31'd0, core_rvalid_io}, 32'd0);
        end
        send(img[nbytes-1]);
        core_re_io = 1'b0;
        chk("load_done", {31'd0, load_done_io}, 32'd1);
        chk("load_hold_drop", {31'd0, core_hold_io}, 32'd0);
        chk("load_ready_drop", {31'd0, load_ready_io}, 32'd0);
        chk("load_err", {31'd0, load_err_io}, 32'd0);
        tick();
        chk("load_done_pulse", {31'd0, load_done_io}, 32'd0);
        chk("load_drop_rvld", {31'd0, core_rvalid_io}, 32'd0);
        tick();
        chk("load_drop_rvld2", {31'd0, core_rvalid_io}, 32'd0);

        // Back-to-back reads, fully pipelined.
        core_re_io = 1'b1; core_addr_io = 10'd0; tick();
        chk("pipe_r0", {31'd0, core_rvalid_io}, 32'd0);
        core_addr_io = 10'd1; tick();
        chk("pipe_v0", {31'd0, core_rvalid_io}, 32'd1);
        chk("pipe_d0", {16'd0, core_rdata_io}, 32'h4F20);
        core_addr_io = 10'd2; tick();
        core_re_io = 1'b0;
        chk("pipe_v1", {31'd0, core_rvalid_io}, 32'd1);
        chk("pipe_d1", {16'd0, core_rdata_io}, 32'h48FF);
        tick();
        chk("pipe_v2", {31'd0, core_rvalid_io}, 32'd1);
        chk("pipe_d2", {16'd0, core_rdata_io}, 32'h5800);
        tick();
        chk("pipe_end", {31'd0, core_rvalid_io}, 32'd0);
        chk("pipe_hold", {16'd0, core_rdata_io}, 32'h5800);

        // Write then read next cycle.
        core_to_mem_enable_io = 1'b1; core_addr_io = 10'd5; core_wdata_io = 16'hBEEF;
        tick();
        core_to_mem_enable_io = 1'b0;
        rd("wr_rd", 10'd5, 16'hBEEF);

        // Simultaneous re+we: write only.
        core_re_io = 1'b1; core_to_mem_enable_io = 1'b1;
        core_addr_io = 10'd6; core_wdata_io = 16'h1234;
        tick();
        core_re_io = 1'b0; core_to_mem_enable_io = 1'b0;
        tick();
        chk("rewe_rvld", {31'd0, core_rvalid_io}, 32'd0);
        tick();
        chk("rewe_rvld2", {31'd0, core_rvalid_io}, 32'd0);
        rd("rewe_wr", 10'd6, 16'h1234);

        // Length overflow, then zero length clears the error.
        start_load(11'd1025);
        chk("ovf_err", {31'd0, load_err_io}, 32'd1);
        chk("ovf_hold", {31'd0, core_hold_io}, 32'd0);
        chk("ovf_ready", {31'd0, load_ready_io}, 32'd0);
        chk("ovf_done", {31'd0, load_done_io}, 32'd0);
        tick();
        chk("ovf_sticky", {31'd0, load_err_io}, 32'd1);
        rd("ovf_mem", 10'd0, 16'h4F20);
        start_load(11'd0);
        chk("zero_done", {31'd0, load_done_io}, 32'd1);
        chk("zero_err_clr", {31'd0, load_err_io}, 32'd0);
        chk("zero_hold", {31'd0, core_hold_io}, 32'd0);
        tick();
        chk("zero_pulse", {31'd0, load_done_io}, 32'd0);
        rd("zero_mem", 10'd1, 16'h48FF);

        // Reset after three bytes of a two-word load.
        start_load(11'd2);
        send(8'hAA); send(8'hBB); send(8'hCC);
        reset_io = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick();
        reset_io = 1'b1;
        tick();
        rd("midrst_w0", 10'd0, 16'hAABB);
        rd("midrst_w1", 10'd1, 16'h48FF);

`ifdef SYNTH_PROG_MEM_CHECKSUM_EN
        start_load(11'd2);
        send(8'h00); send(8'h01);
        load_byte_io = 8'h77; tick();
        send(8'h00); send(8'h02); send(8'h00);
        chk("cks_ok_wait", {31'd0, load_done_io}, 32'd0);
        send(8'h03);
        chk("cks_ok_done", {31'd0, load_done_io}, 32'd1);
        chk("cks_ok_err", {31'd0, load_err_io}, 32'd0);
        tick();
        start_load(11'd2);
        send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'h00); send(8'h04);
        chk("cks_bad_done", {31'd0, load_done_io}, 32'd1);
        chk("cks_bad_err", {31'd0, load_err_io}, 32'd1);
        tick();
`else
        start_load(11'd2);
        send(8'h00); send(8'h01);
        load_byte_io = 8'h77; tick();
        send(8'h00);
        chk("nocks_wait", {31'd0, load_done_io}, 32'd0);
        send(8'h02);
        chk("nocks_done", {31'd0, load_done_io}, 32'd1);
        chk("nocks_err", {31'd0, load_err_io}, 32'd0);
        tick();
`endif
        rd("cks_w0", 10'd0, 16'h0001);
        rd("cks_w1", 10'd1, 16'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
